// File: rtl/phased_counter_pkg.sv
// Shared defaults and helpers for the phase-gated counter and its implication monitor.
package phased_counter_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PHASES   = 2;
  localparam int DEF_STEP     = 2;
  localparam int DEF_SATURATE = 0;
  localparam int DEF_ANT_MASK = 1;
  localparam int DEF_DELAY    = 1;
  localparam int DEF_BOUND    = 5;
  localparam int DEF_FCW      = 8;

  function automatic logic [63:0] win_lo(int k, int step);
    return 64'(k) * 64'(step);
  endfunction

  // Inclusive upper bound; the last phase absorbs everything up to the count maximum.
  function automatic logic [63:0] win_hi(int k, int step, int phases, int width);
    logic [63:0] max_v;
    logic [63:0] hi;
    max_v = (64'd1 << width) - 64'd1;
    if (k == phases - 1) hi = max_v;
    else                 hi = win_lo(k + 1, step) - 64'd1;
    return (hi > max_v) ? max_v : hi;
  endfunction

  function automatic logic [63:0] sat_inc(logic [63:0] v, logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/phased_counter_monitor_mon.sv
// Bounded-implication checker: delayed antecedent must imply count < BOUND.
module implication_monitor
  import phased_counter_pkg::*;
#(
  parameter int DELAY = DEF_DELAY,
  parameter int WIDTH = DEF_WIDTH,
  parameter int BOUND = DEF_BOUND,
  parameter int FCW   = DEF_FCW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ant,
  input  logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             fail,
  output logic [FCW-1:0]   fail_count,
  output logic [WIDTH-1:0] fail_at
);

  localparam logic [63:0] FC_MAX  = (64'd1 << FCW) - 64'd1;
  localparam logic [63:0] BOUND_L = 64'(BOUND);

  logic [DELAY-1:0] dly;
  logic             ant_d;

  assign ant_d = dly[DELAY-1];
  // Wide compare so a BOUND beyond the count range simply makes valid constant 1.
  assign valid = ~ant_d | (64'(count) < BOUND_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dly <= '0;
    else     dly <= (dly << 1) | DELAY'(ant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail       <= 1'b0;
      fail_count <= '0;
      fail_at    <= '0;
    end else if (!valid) begin
      fail       <= 1'b1;
      fail_count <= FCW'(sat_inc(64'(fail_count), FC_MAX));
      if (!fail) fail_at <= count;
    end
  end

endmodule

// File: rtl/phased_counter_monitor.sv
// Phase-gated up-counter: each enable may advance the count only inside its own window.
module phased_counter_monitor
  import phased_counter_pkg::*;
#(
  parameter int                WIDTH    = DEF_WIDTH,
  parameter int                PHASES   = DEF_PHASES,
  parameter int                STEP     = DEF_STEP,
  parameter int                SATURATE = DEF_SATURATE,
  parameter logic [PHASES-1:0] ANT_MASK = PHASES'(DEF_ANT_MASK),
  parameter int                DELAY    = DEF_DELAY,
  parameter int                BOUND    = DEF_BOUND,
  parameter int                FCW      = DEF_FCW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PHASES-1:0] ena,
  input  logic              clr,
  output logic [WIDTH-1:0]  count,
  output logic              valid,
  output logic              fail,
  output logic [FCW-1:0]    fail_count,
  output logic [WIDTH-1:0]  fail_at
);

  localparam logic [63:0] CNT_MAX = (64'd1 << WIDTH) - 64'd1;

  logic [PHASES-1:0] active;
  logic [63:0]       count_ext;
  logic              advance;
  logic              ant;

  assign count_ext = 64'(count);

  for (genvar k = 0; k < PHASES; k++) begin : g_win
    localparam logic [63:0] LO = win_lo(k, STEP);
    localparam logic [63:0] HI = win_hi(k, STEP, PHASES, WIDTH);
    // count >= LO written as count+1 > LO so a zero lower bound needs no special case.
    assign active[k] = ena[k] && ({1'b0, count_ext} + 65'd1 > {1'b0, LO}) && (count_ext <= HI);
  end

  assign advance = |active;
  assign ant     = |(ena & ANT_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (clr)     count <= '0;
    else if (advance) begin
      if (SATURATE != 0) count <= WIDTH'(sat_inc(count_ext, CNT_MAX));
      else               count <= count + WIDTH'(1);
    end
  end

  implication_monitor #(
    .DELAY(DELAY),
    .WIDTH(WIDTH),
    .BOUND(BOUND),
    .FCW  (FCW)
  ) u_mon (
    .clk       (clk),
    .rst       (rst),
    .ant       (ant),
    .count     (count),
    .valid     (valid),
    .fail      (fail),
    .fail_count(fail_count),
    .fail_at   (fail_at)
  );

endmodule

// File: tb/tb_phased_counter_monitor.sv
// Bench for phased_counter_monitor: default, SATURATE=1 and DELAY=3 instances share stimulus.
module tb_phased_counter_monitor;

  localparam int W = 4, P = 2, STEP = 2, BOUND = 5, FCW = 8;
  localparam int CMAX = 15, FCMAX = 255;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic [P-1:0]   ena = '0;
  logic [W-1:0]   cnt[3];
  logic [W-1:0]   fat[3];
  logic           vld[3];
  logic           fl[3];
  logic [FCW-1:0] fcnt[3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  phased_counter_monitor u_def (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .count(cnt[0]), .valid(vld[0]),
    .fail(fl[0]), .fail_count(fcnt[0]), .fail_at(fat[0]));

  phased_counter_monitor #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .count(cnt[1]), .valid(vld[1]),
    .fail(fl[1]), .fail_count(fcnt[1]), .fail_at(fat[1]));

  phased_counter_monitor #(.DELAY(3)) u_d3 (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .count(cnt[2]), .valid(vld[2]),
    .fail(fl[2]), .fail_count(fcnt[2]), .fail_at(fat[2]));

  // Reference model: counts as integers, antecedent history as a plain array (hist[0] newest).
  int m_cnt[3];
  int m_fc[3];
  int m_fa[3];
  bit m_fail[3];
  bit hist[8];

  function automatic int dly_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int phase_of(int c);
    int p;
    p = c / STEP;
    return (p > P - 1) ? P - 1 : p;
  endfunction

  function automatic bit m_valid(int i);
    return !hist[dly_of(i) - 1] || (m_cnt[i] < BOUND);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_fc[i] = 0; m_fa[i] = 0; m_fail[i] = 0;
    end
    for (int j = 0; j < 8; j++) hist[j] = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_valid(i)) begin
          if (!m_fail[i]) m_fa[i] = m_cnt[i];
          m_fail[i] = 1;
          if (m_fc[i] < FCMAX) m_fc[i]++;
        end
        if (clr) m_cnt[i] = 0;
        else if (ena[phase_of(m_cnt[i])])
          m_cnt[i] = (i == 1 && m_cnt[i] == CMAX) ? CMAX : (m_cnt[i] + 1) % (CMAX + 1);
      end
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = ena[0];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ena = '0; clr = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [P-1:0] ena;
    logic         clr;
    int           cnt;
    bit           vld;
    bit           fl;
    int           fc;
    int           fa;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{2'b01, 1'b0, 1, 1, 0, 0, 0};
    tbl[1]  = '{2'b01, 1'b0, 2, 1, 0, 0, 0};
    tbl[2]  = '{2'b01, 1'b0, 2, 1, 0, 0, 0};
    tbl[3]  = '{2'b10, 1'b0, 3, 1, 0, 0, 0};
    tbl[4]  = '{2'b10, 1'b0, 4, 1, 0, 0, 0};
    tbl[5]  = '{2'b10, 1'b0, 5, 1, 0, 0, 0};
    tbl[6]  = '{2'b10, 1'b0, 6, 1, 0, 0, 0};
    tbl[7]  = '{2'b11, 1'b0, 7, 0, 0, 0, 0};
    tbl[8]  = '{2'b10, 1'b0, 8, 1, 1, 1, 7};
    tbl[9]  = '{2'b01, 1'b1, 0, 1, 1, 1, 7};
    tbl[10] = '{2'b01, 1'b1, 0, 1, 1, 1, 7};
    tbl[11] = '{2'b00, 1'b0, 0, 1, 1, 1, 7};

    m_reset();
    #12;
    chk("rst_count", cnt[0], 0);
    chk("rst_valid", vld[0], 1);
    chk("rst_fail", fl[0], 0);
    chk("rst_fail_count", fcnt[0], 0);
    chk("rst_fail_at", fat[0], 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      ena = tbl[i].ena; clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), cnt[0], tbl[i].cnt);
      chk($sformatf("tbl%0d_valid", i), vld[0], tbl[i].vld);
      chk($sformatf("tbl%0d_fail", i), fl[0], tbl[i].fl);
      chk($sformatf("tbl%0d_fail_count", i), fcnt[0], tbl[i].fc);
      chk($sformatf("tbl%0d_fail_at", i), fat[0], tbl[i].fa);
    end

    // Wrap versus saturate, with masked-out phase 1 never failing.
    do_reset();
    ena = 2'b01;
    repeat (2) @(negedge clk);
    ena = 2'b10;
    for (int s = 3; s <= 15; s++) begin
      @(negedge clk);
      chk("wrap_count", cnt[0], s);
      chk("sat_count", cnt[1], s);
      chk("masked_valid", vld[0], 1);
    end
    repeat (2) begin
      @(negedge clk);
      chk("wrap_to_zero", cnt[0], 0);
      chk("sat_hold", cnt[1], 15);
    end
    chk("masked_no_fail", fl[0], 0);

    // Antecedent failure from reset, then asynchronous reset mid-failure.
    do_reset();
    ena = 2'b11;
    repeat (5) @(negedge clk);
    chk("ant_count5", cnt[0], 5);
    chk("ant_valid_low", vld[0], 0);
    chk("ant_fail_not_yet", fl[0], 0);
    @(negedge clk);
    chk("ant_fail_set", fl[0], 1);
    chk("ant_fail_at", fat[0], 5);
    chk("ant_fail_count1", fcnt[0], 1);
    repeat (3) @(negedge clk);
    chk("ant_fail_count4", fcnt[0], 4);
    chk("ant_fail_at_kept", fat[0], 5);
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk("arst_count", cnt[0], 0);
    chk("arst_valid", vld[0], 1);
    chk("arst_fail", fl[0], 0);
    chk("arst_fail_count", fcnt[0], 0);
    chk("arst_fail_at", fat[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // clr beats an advance at count 1.
    ena = 2'b01;
    @(negedge clk);
    chk("pre_clr_count", cnt[0], 1);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_wins", cnt[0], 0);
    clr = 1'b0;

    // Three-stage antecedent delay: single pulse at count 6.
    do_reset();
    ena = 2'b01;
    repeat (2) @(negedge clk);
    ena = 2'b10;
    repeat (4) @(negedge clk);
    chk("d3_count6", cnt[2], 6);
    ena = 2'b01;
    @(negedge clk);
    chk("d3_valid_e1", vld[2], 1);
    ena = 2'b00;
    @(negedge clk);
    chk("d3_valid_e2", vld[2], 1);
    @(negedge clk);
    chk("d3_valid_e3", vld[2], 0);
    @(negedge clk);
    chk("d3_valid_e4", vld[2], 1);
    chk("d3_fail_count", fcnt[2], 1);
    chk("d3_fail_at", fat[2], 6);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      ena = P'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rnd_count[%0d]", i), cnt[i], m_cnt[i]);
        chk($sformatf("rnd_valid[%0d]", i), vld[i], m_valid(i));
        chk($sformatf("rnd_fail[%0d]", i), fl[i], m_fail[i]);
        chk($sformatf("rnd_fail_count[%0d]", i), fcnt[i], m_fc[i]);
        chk($sformatf("rnd_fail_at[%0d]", i), fat[i], m_fa[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
